// File: rtl/life_pkg.sv
// life_pkg: map geometry and scanner state encoding shared by the life engine and display blocks.
package life_pkg;
  localparam int MAP_W = 16;
  localparam int MAP_H = 16;
  localparam int MAP_BITS = MAP_W * MAP_H;
  localparam int X_W = $clog2(MAP_W);
  localparam int Y_W = $clog2(MAP_H);
  typedef enum logic [2:0] {S_LOAD, S_SHIFT, S_BLANK, S_LATCH, S_SHOW} scan_state_t;
endpackage

// File: rtl/row_serializer.sv
// row_serializer: shifts a 16-bit word MSB first; each bit is CLK_DIV clocks with sclk low, then CLK_DIV clocks with sclk high.
module row_serializer #(
  parameter int CLK_DIV = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] word,
  output logic        sclk,
  output logic        sdata,
  output logic        done
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  logic          active, high, tick;
  logic [CW-1:0] cnt;
  logic [3:0]    bits;
  logic [15:0]   shreg;
  assign tick  = cnt == CNT_LAST;
  assign sclk  = active & high;
  assign sdata = active & shreg[15];
  assign done  = active & high & tick & (bits == 4'd15);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      high   <= 1'b0;
      cnt    <= '0;
      bits   <= '0;
      shreg  <= '0;
    end else if (start) begin
      active <= 1'b1;
      high   <= 1'b0;
      cnt    <= '0;
      bits   <= '0;
      shreg  <= word;
    end else if (active) begin
      cnt    <= tick ? '0 : cnt + 1'b1;
      active <= !done;
      if (tick) begin
        high <= !high;
        if (high) begin
          shreg <= shreg << 1;
          bits  <= bits + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/map_matrix_scanner.sv
// map_matrix_scanner: scans a snapshotted 16x16 life map row by row onto a shift-register LED matrix with a blinking cursor.
module map_matrix_scanner
  import life_pkg::*;
#(
  parameter int CLK_DIV      = 250,
  parameter int ROW_HOLD     = 50_000,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [MAP_BITS-1:0] map,
  input  logic [X_W-1:0]      cursor_x,
  input  logic [Y_W-1:0]      cursor_y,
  input  logic                cursor_en,
  output logic                sclk,
  output logic                sdata,
  output logic                slatch,
  output logic                oe_n,
  output logic [Y_W-1:0]      row_sel,
  output logic                frame_start
);
  localparam int HW = ROW_HOLD > 1 ? $clog2(ROW_HOLD) : 1;
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(ROW_HOLD - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  scan_state_t         state, next;
  logic [Y_W-1:0]      r, cur_y, snap_y;
  logic [X_W-1:0]      cur_x, snap_x;
  logic [HW-1:0]       hold;
  logic [BW-1:0]       frames;
  logic                phase, snap_phase, snap_en, cur_en, cur_phase, first, ser_done;
  logic [MAP_BITS-1:0] snap, src;
  logic [MAP_W-1:0]    base, word;
  // The r==0 LOAD row must see the inputs being snapshotted in that same cycle.
  assign first       = state == S_LOAD && r == '0;
  assign frame_start = first & rst_n;
  assign slatch      = state == S_LATCH;
  assign src         = first ? map : snap;
  assign cur_x       = first ? cursor_x : snap_x;
  assign cur_y       = first ? cursor_y : snap_y;
  assign cur_en      = first ? cursor_en : snap_en;
  assign cur_phase   = first ? phase : snap_phase;
  assign base        = src[r*MAP_W +: MAP_W];
  assign word        = base ^ (MAP_W'(cur_en && cur_y == r && cur_phase) << cur_x);
  always_comb begin
    next = state;
    unique case (state)
      S_LOAD:  next = S_SHIFT;
      S_SHIFT: next = ser_done ? S_BLANK : S_SHIFT;
      S_BLANK: next = S_LATCH;
      S_LATCH: next = S_SHOW;
      S_SHOW:  next = hold == HOLD_LAST ? S_LOAD : S_SHOW;
      default: next = S_LOAD;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_LOAD;
      r          <= '0;
      hold       <= '0;
      frames     <= '0;
      phase      <= 1'b0;
      snap       <= '0;
      snap_x     <= '0;
      snap_y     <= '0;
      snap_en    <= 1'b0;
      snap_phase <= 1'b0;
      oe_n       <= 1'b1;
      row_sel    <= '0;
    end else begin
      state <= next;
      hold  <= state == S_SHOW ? hold + 1'b1 : '0;
      if (state == S_SHOW && next == S_LOAD) r <= r + 1'b1;
      if (next == S_BLANK) oe_n <= 1'b1;
      if (next == S_SHOW) oe_n <= 1'b0;
      if (next == S_LATCH) row_sel <= r;
      // The phase sampled here is the pre-toggle value, so a toggle takes effect next frame.
      if (first) begin
        snap       <= map;
        snap_x     <= cursor_x;
        snap_y     <= cursor_y;
        snap_en    <= cursor_en;
        snap_phase <= phase;
        frames     <= frames == BLINK_LAST ? '0 : frames + 1'b1;
        if (frames == BLINK_LAST) phase <= !phase;
      end
    end
  end
  row_serializer #(.CLK_DIV(CLK_DIV)) u_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .start (state == S_LOAD),
    .word  (word),
    .sclk  (sclk),
    .sdata (sdata),
    .done  (ser_done)
  );
endmodule
